store_buffer: RTL and testbench

//  Word-store buffer between the core's MEM stage and data_mem. It queues stores so the core never stalls on the write port.

---
 rtl/store_buffer_pkg.sv | 16 +
 rtl/sb_fwd_match.sv | 37 +++
 rtl/store_buffer.sv | 144 ++++++++++++++
 tb/tb_store_buffer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared defaults and types for the word-store buffer and its forwarding matcher.
// The width defaults match the data_mem port that the buffer drains into.
package store_buffer_pkg;

  localparam int unsigned SB_ADDR_WIDTH = 10;
  localparam int unsigned SB_DATA_WIDTH = 32;
  localparam int unsigned SB_DEPTH      = 4;

  // Owner of the single data_mem port in the current cycle.
  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_RD   = 2'd1,
    MEM_WR   = 2'd2
  } mem_op_e;

endpackage

// File: rtl/sb_fwd_match.sv
// DEPTH-way compare of a load address against buffered stores.
// When several entries match, the youngest one (nearest tail-1) supplies the data.
module sb_fwd_match
  import store_buffer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = SB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = SB_DATA_WIDTH,
  parameter int unsigned DEPTH      = SB_DEPTH
) (
  input  logic [ADDR_WIDTH-1:0]      ld_addr,
  input  logic [ADDR_WIDTH-1:0]      ent_addr [DEPTH],
  input  logic [DATA_WIDTH-1:0]      ent_data [DEPTH],
  input  logic [DEPTH-1:0]           valid,
  input  logic [$clog2(DEPTH)-1:0]   tail,
  output logic                       hit,
  output logic [DATA_WIDTH-1:0]      data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] idx;

  // Walk from youngest to oldest; the first valid match stops the search.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = tail - PTR_W'(1) - PTR_W'(i);
      if (!hit && valid[idx] && (ent_addr[idx] == ld_addr)) begin
        hit  = 1'b1;
        data = ent_data[idx];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Word-store buffer between the MEM stage and data_mem: stores queue in a FIFO,
// loads take the memory port with priority and forward from pending stores.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = SB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = SB_DATA_WIDTH,
  parameter int unsigned DEPTH      = SB_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       st_valid,
  output logic                       st_ready,
  input  logic [ADDR_WIDTH-1:0]      st_addr,
  input  logic [DATA_WIDTH-1:0]      st_data,
  input  logic                       ld_req,
  input  logic [ADDR_WIDTH-1:0]      ld_addr,
  output logic [DATA_WIDTH-1:0]      ld_data,
  output logic                       ld_fwd,
  output logic                       sb_empty,
  output logic [$clog2(DEPTH):0]     sb_count,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_wdata,
  input  logic [DATA_WIDTH-1:0]      mem_rdata
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_d [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_d [DEPTH];

  logic                  full, push, pop;
  logic                  fwd_hit;
  logic [DATA_WIDTH-1:0] fwd_data;
  mem_op_e               mem_op;

  sb_fwd_match #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fwd (
    .ld_addr  (ld_addr),
    .ent_addr (addr_q),
    .ent_data (data_q),
    .valid    (valid_q),
    .tail     (tail_q),
    .hit      (fwd_hit),
    .data     (fwd_data)
  );

  // Port arbitration: a load always wins; otherwise drain the head entry.
  always_comb begin
    mem_op = MEM_IDLE;
    if (ld_req) begin
      mem_op = MEM_RD;
    end else if (count_q != '0) begin
      mem_op = MEM_WR;
    end
  end

  // Push/pop bookkeeping; a full buffer refuses stores even while draining.
  always_comb begin
    full    = (count_q == CNT_W'(DEPTH));
    push    = st_valid && !full;
    pop     = (mem_op == MEM_WR);
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (pop) begin
      head_d          = head_q + PTR_W'(1);
      valid_d[head_q] = 1'b0;
    end
    if (push) begin
      tail_d          = tail_q + PTR_W'(1);
      valid_d[tail_q] = 1'b1;
      addr_d[tail_q]  = st_addr;
      data_d[tail_q]  = st_data;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Core-facing and memory-facing outputs, all combinational from state.
  always_comb begin
    st_ready  = !full;
    sb_empty  = (count_q == '0);
    sb_count  = count_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    ld_data   = '0;
    ld_fwd    = 1'b0;
    case (mem_op)
      MEM_RD: begin
        mem_read = 1'b1;
        mem_addr = ld_addr;
        ld_fwd   = fwd_hit;
        ld_data  = fwd_hit ? fwd_data : mem_rdata;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        mem_addr  = addr_q[head_q];
        mem_wdata = data_q[head_q];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer against a behavioural data_mem with
// combinational read and posedge write.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [9:0]  st_addr;
  logic [31:0] st_data;
  logic        ld_req;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;
  logic        ld_fwd;
  logic        sb_empty;
  logic [2:0]  sb_count;
  logic        mem_read;
  logic        mem_write;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [1024];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  store_buffer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .ld_req    (ld_req),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .ld_fwd    (ld_fwd),
    .sb_empty  (sb_empty),
    .sb_count  (sb_count),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // data_mem stand-in, preloaded while in reset.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      mem[7] <= 32'h77;
    end else if (mem_write) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic v, input logic [9:0] a, input logic [31:0] d);
    st_valid = v;
    st_addr  = a;
    st_data  = d;
  endtask

  task automatic drain_wait();
    for (int i = 0; i < 20 && !sb_empty; i++) tick();
    chk("drain_done", 64'(sb_empty), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    store(1'b0, 10'd0, 32'h0);
    ld_req  = 1'b0;
    ld_addr = 10'd0;
    tick();
    tick();
    chk("rst_ready", 64'(st_ready), 64'd1);
    chk("rst_empty", 64'(sb_empty), 64'd1);
    chk("rst_count", 64'(sb_count), 64'd0);
    chk("rst_mem_wr", 64'({mem_read, mem_write}), 64'd0);
    chk("rst_fwd", 64'(ld_fwd), 64'd0);
    rst_n = 1'b1;
    tick();

    // Drain order with concurrent push and pop.
    store(1'b1, 10'd5, 32'hA);
    #1 chk("drain_c0_wr", 64'(mem_write), 64'd0);
    tick();
    store(1'b1, 10'd6, 32'hB);
    #1 chk("drain_c1", 64'({mem_write, mem_addr, mem_wdata}), {1'b1, 10'd5, 32'hA});
    tick();
    store(1'b1, 10'd5, 32'hC);
    #1 chk("drain_c2", 64'({mem_write, mem_addr, mem_wdata}), {1'b1, 10'd6, 32'hB});
    tick();
    store(1'b0, 10'd0, 32'h0);
    #1 chk("drain_c3", 64'({mem_write, mem_addr, mem_wdata}), {1'b1, 10'd5, 32'hC});
    chk("drain_c3_cnt", 64'(sb_count), 64'd1);
    tick();
    chk("drain_empty", 64'(sb_empty), 64'd1);
    chk("drain_mem5", 64'(mem[5]), 64'hC);
    chk("drain_idle", 64'(mem_write), 64'd0);

    // Forwarding: hold a load elsewhere so both entries stay buffered.
    ld_req  = 1'b1;
    ld_addr = 10'd7;
    store(1'b1, 10'd5, 32'h1A);
    #1 chk("ld_mem7", 64'({ld_fwd, ld_data}), {1'b0, 32'h77});
    tick();
    store(1'b1, 10'd5, 32'h1C);
    tick();
    store(1'b0, 10'd0, 32'h0);
    ld_addr = 10'd5;
    #1 chk("fwd_young", 64'({ld_fwd, ld_data}), {1'b1, 32'h1C});
    chk("fwd_rd", 64'({mem_read, mem_write, mem_addr}), {1'b1, 1'b0, 10'd5});
    ld_req = 1'b0;
    #1 chk("ld_idle_data", 64'({ld_fwd, ld_data}), 64'd0);
    drain_wait();
    chk("fwd_mem5", 64'(mem[5]), 64'h1C);

    // Fill to DEPTH while loads hog the port.
    ld_req  = 1'b1;
    ld_addr = 10'd7;
    for (int i = 1; i <= 4; i++) begin
      store(1'b1, 10'(i), 32'(i * 17));
      tick();
    end
    store(1'b1, 10'd8, 32'h88);
    ld_addr = 10'd3;
    #1 chk("full_cnt", 64'(sb_count), 64'd4);
    chk("full_ready", 64'(st_ready), 64'd0);
    chk("full_nowr", 64'({mem_read, mem_write}), 64'b10);
    chk("full_fwd3", 64'({ld_fwd, ld_data}), {1'b1, 32'h33});
    tick();
    chk("full_hold", 64'(sb_count), 64'd4);
    ld_req = 1'b0;
    #1 chk("full_pop1", 64'({mem_write, mem_addr, mem_wdata}), {1'b1, 10'd1, 32'h11});
    chk("full_nopass", 64'(st_ready), 64'd0);
    tick();
    chk("full_after_pop", 64'({st_ready, sb_count}), {1'b1, 3'd3});
    chk("full_pop2", 64'({mem_addr, mem_wdata}), {10'd2, 32'h22});
    tick();
    store(1'b0, 10'd0, 32'h0);
    #1 chk("full_pushpop", 64'(sb_count), 64'd3);
    drain_wait();
    chk("full_mem4", 64'(mem[4]), 64'h44);
    chk("full_mem8", 64'(mem[8]), 64'h88);

    // Wrap-around: one push and one pop per cycle.
    store(1'b1, 10'd16, 32'h100);
    tick();
    for (int i = 1; i < 10; i++) begin
      store(1'b1, 10'(16 + i), 32'(256 + i));
      #1 chk("wrap_wr", 64'({mem_write, mem_addr, mem_wdata}), {1'b1, 10'(15 + i), 32'(255 + i)});
      chk("wrap_cnt", 64'(sb_count), 64'd1);
      tick();
    end
    store(1'b0, 10'd0, 32'h0);
    #1 chk("wrap_last", 64'({mem_addr, mem_wdata}), {10'd25, 32'h109});
    drain_wait();

    // Same-cycle push is invisible to the concurrent load.
    ld_req  = 1'b1;
    ld_addr = 10'd9;
    store(1'b1, 10'd9, 32'h1);
    #1 chk("haz_same", 64'({ld_fwd, ld_data}), {1'b1 ^ 1'b1, 32'h0});
    tick();
    store(1'b0, 10'd0, 32'h0);
    #1 chk("haz_next", 64'({ld_fwd, ld_data}), {1'b1, 32'h1});
    ld_req = 1'b0;
    drain_wait();

    // Reset mid-drain with three pending stores.
    ld_req  = 1'b1;
    ld_addr = 10'd7;
    for (int i = 0; i < 3; i++) begin
      store(1'b1, 10'(30 + i), 32'(48 + i));
      tick();
    end
    store(1'b0, 10'd0, 32'h0);
    ld_req = 1'b0;
    #1 chk("mid_wr", 64'({mem_write, sb_count}), {1'b1, 3'd3});
    rst_n = 1'b0;
    #1 chk("mid_rst", 64'({sb_count, sb_empty, mem_write, st_ready}), {3'd0, 1'b1, 1'b0, 1'b1});
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", 64'({mem_write, sb_empty}), {1'b0, 1'b1});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
